sfx_player: RTL and testbench

SFX_PLAYER -- requirements
Module: sfx_player

---
 rtl/sfx_player_if.sv | 22 ++
 rtl/sfx_player.sv | 127 ++++++++++++
 tb/tb_sfx_player.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sfx_player_if.sv
// Control and output bundle between the sound-effect player and its host.
// The host drives requests; the player drives the registered note outputs.
interface sfx_player_if;
    logic        step_en;
    logic [2:0]  trigger;
    logic        abort;
    logic [21:0] note_div;
    logic        active;
    logic        done;
    logic [1:0]  effect_id;
    logic [2:0]  step_idx;

    modport master (
        output step_en, trigger, abort,
        input  note_div, active, done, effect_id, step_idx
    );

    modport slave (
        input  step_en, trigger, abort,
        output note_div, active, done, effect_id, step_idx
    );
endinterface

// File: rtl/sfx_player.sv
// Plays short fixed sound effects as a sequence of note dividers, one entry per step_en.
// Higher or equal effect ids preempt the current one; abort stops without a done pulse.
module sfx_player #(
    parameter int unsigned DIV_NUM    = 50000000,
    parameter int unsigned SILENT_DIV = 1
) (
    input logic         clk,
    input logic         rst,
    sfx_player_if.slave bus
);

    localparam logic [21:0] D988   = 22'(DIV_NUM / 988);
    localparam logic [21:0] D1319  = 22'(DIV_NUM / 1319);
    localparam logic [21:0] D392   = 22'(DIV_NUM / 392);
    localparam logic [21:0] D330   = 22'(DIV_NUM / 330);
    localparam logic [21:0] D262   = 22'(DIV_NUM / 262);
    localparam logic [21:0] D196   = 22'(DIV_NUM / 196);
    localparam logic [21:0] D523   = 22'(DIV_NUM / 523);
    localparam logic [21:0] D659   = 22'(DIV_NUM / 659);
    localparam logic [21:0] D784   = 22'(DIV_NUM / 784);
    localparam logic [21:0] D1046  = 22'(DIV_NUM / 1046);
    localparam logic [21:0] DSILENT = 22'(SILENT_DIV);

    typedef enum logic [0:0] {StIdle, StPlay} state_e;

    state_e      state_q;
    logic [21:0] note_div_q;
    logic        active_q;
    logic        done_q;
    logic [1:0]  effect_id_q;
    logic [2:0]  step_idx_q;

    logic        trig_valid;
    logic [1:0]  trig_id;
    logic [2:0]  last_idx;
    logic [2:0]  next_idx;

    function automatic logic [21:0] entry_div(input logic [1:0] id, input logic [2:0] idx);
        logic [21:0] d;
        d = DSILENT;
        unique case (id)
            2'd1: d = (idx == 3'd0) ? D988 : D1319;
            2'd2: begin
                unique case (idx)
                    3'd0:    d = D392;
                    3'd1:    d = D330;
                    3'd2:    d = D262;
                    default: d = D196;
                endcase
            end
            2'd3: begin
                unique case (idx)
                    3'd0:    d = D523;
                    3'd1:    d = D659;
                    3'd2:    d = D784;
                    3'd4:    d = D784;
                    default: d = D1046;
                endcase
            end
            default: d = DSILENT;
        endcase
        return d;
    endfunction

    assign trig_id    = bus.trigger[1:0];
    assign trig_valid = !bus.trigger[2] && (trig_id != 2'd0);
    assign last_idx   = (effect_id_q == 2'd3) ? 3'd5 : 3'd3;
    assign next_idx   = 3'(step_idx_q + 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            note_div_q  <= DSILENT;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            effect_id_q <= 2'd0;
            step_idx_q  <= 3'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // abort outranks trigger even when nothing is playing
                    if (trig_valid && !bus.abort) begin
                        state_q     <= StPlay;
                        note_div_q  <= entry_div(trig_id, 3'd0);
                        active_q    <= 1'b1;
                        effect_id_q <= trig_id;
                        step_idx_q  <= 3'd0;
                    end
                end
                StPlay: begin
                    if (bus.abort) begin
                        state_q     <= StIdle;
                        note_div_q  <= DSILENT;
                        active_q    <= 1'b0;
                        effect_id_q <= 2'd0;
                        step_idx_q  <= 3'd0;
                    end else if (trig_valid && (trig_id >= effect_id_q)) begin
                        note_div_q  <= entry_div(trig_id, 3'd0);
                        effect_id_q <= trig_id;
                        step_idx_q  <= 3'd0;
                    end else if (bus.step_en) begin
                        if (step_idx_q == last_idx) begin
                            state_q     <= StIdle;
                            note_div_q  <= DSILENT;
                            active_q    <= 1'b0;
                            done_q      <= 1'b1;
                            effect_id_q <= 2'd0;
                            step_idx_q  <= 3'd0;
                        end else begin
                            note_div_q <= entry_div(effect_id_q, next_idx);
                            step_idx_q <= next_idx;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.note_div  = note_div_q;
    assign bus.active    = active_q;
    assign bus.done      = done_q;
    assign bus.effect_id = effect_id_q;
    assign bus.step_idx  = step_idx_q;

endmodule

// File: tb/tb_sfx_player.sv
// Directed, table-driven bench for sfx_player: one vector per clk, plus
// hand-written sequences for asynchronous reset and post-reset restart.
module tb_sfx_player;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_bad;

    sfx_player_if bus ();

    sfx_player #(
        .DIV_NUM   (50000000),
        .SILENT_DIV(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  trig;
        logic        step;
        logic        abrt;
        logic [21:0] exp_div;
        logic        exp_act;
        logic        exp_done;
        logic [1:0]  exp_id;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] t, input logic s, input logic a, input int nd,
                       input logic act, input logic dn, input int id, input int idx);
        vec_t v;
        v.trig     = t;
        v.step     = s;
        v.abrt     = a;
        v.exp_div  = 22'(nd);
        v.exp_act  = act;
        v.exp_done = dn;
        v.exp_id   = 2'(id);
        v.exp_idx  = 3'(idx);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int nd, input logic act, input logic dn,
                           input int id, input int idx);
        chk({tag, " note_div"}, int'(bus.note_div), nd);
        chk({tag, " active"}, int'(bus.active), int'(act));
        chk({tag, " done"}, int'(bus.done), int'(dn));
        chk({tag, " effect_id"}, int'(bus.effect_id), id);
        chk({tag, " step_idx"}, int'(bus.step_idx), idx);
    endtask

    // Inputs are applied 1 time unit after a rising edge and sampled at the next one.
    task automatic apply(input logic [2:0] t, input logic s, input logic a);
        bus.trigger = t;
        bus.step_en = s;
        bus.abort   = a;
        @(posedge clk);
        #1;
        bus.trigger = 3'd0;
        bus.step_en = 1'b0;
        bus.abort   = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_bad       = 0;
        bus.trigger = 3'd0;
        bus.step_en = 1'b0;
        bus.abort   = 1'b0;
        rst         = 1'b1;

        // trig step abort | note_div act done id idx
        add(3'd1, 0, 0, 50607, 1, 0, 1, 0);
        add(3'd0, 1, 0, 37907, 1, 0, 1, 1);
        add(3'd0, 1, 0, 37907, 1, 0, 1, 2);
        add(3'd0, 1, 0, 37907, 1, 0, 1, 3);
        add(3'd0, 1, 0, 1, 0, 1, 0, 0);
        add(3'd0, 0, 0, 1, 0, 0, 0, 0);
        add(3'd0, 1, 0, 1, 0, 0, 0, 0);
        add(3'd0, 1, 0, 1, 0, 0, 0, 0);
        add(3'd2, 0, 0, 127551, 1, 0, 2, 0);
        add(3'd1, 0, 0, 127551, 1, 0, 2, 0);
        add(3'd0, 1, 0, 151515, 1, 0, 2, 1);
        add(3'd2, 0, 1, 1, 0, 0, 0, 0);
        add(3'd0, 0, 1, 1, 0, 0, 0, 0);
        add(3'd5, 0, 0, 1, 0, 0, 0, 0);
        add(3'd3, 0, 0, 95602, 1, 0, 3, 0);
        add(3'd0, 1, 0, 75872, 1, 0, 3, 1);
        add(3'd0, 1, 0, 63775, 1, 0, 3, 2);
        add(3'd2, 0, 0, 63775, 1, 0, 3, 2);
        add(3'd3, 1, 0, 95602, 1, 0, 3, 0);
        add(3'd7, 1, 0, 75872, 1, 0, 3, 1);
        add(3'd0, 1, 0, 63775, 1, 0, 3, 2);
        add(3'd0, 1, 0, 47801, 1, 0, 3, 3);
        add(3'd0, 1, 0, 63775, 1, 0, 3, 4);
        add(3'd0, 1, 0, 47801, 1, 0, 3, 5);
        add(3'd0, 1, 0, 1, 0, 1, 0, 0);
        add(3'd1, 0, 0, 50607, 1, 0, 1, 0);
        add(3'd3, 0, 0, 95602, 1, 0, 3, 0);
        add(3'd3, 0, 0, 95602, 1, 0, 3, 0);
        add(3'd0, 1, 0, 75872, 1, 0, 3, 1);
        add(3'd3, 1, 0, 95602, 1, 0, 3, 0);
        add(3'd0, 1, 1, 1, 0, 0, 0, 0);
        add(3'd2, 0, 0, 127551, 1, 0, 2, 0);
        add(3'd0, 1, 0, 151515, 1, 0, 2, 1);
        add(3'd0, 1, 0, 190839, 1, 0, 2, 2);
        add(3'd0, 1, 0, 255102, 1, 0, 2, 3);
        add(3'd0, 1, 0, 1, 0, 1, 0, 0);
        add(3'd0, 0, 0, 1, 0, 0, 0, 0);

        #3;
        chk_all("reset", 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("post_reset", 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].trig, vecs[i].step, vecs[i].abrt);
            chk_all($sformatf("vec%0d", i), int'(vecs[i].exp_div), vecs[i].exp_act,
                    vecs[i].exp_done, int'(vecs[i].exp_id), int'(vecs[i].exp_idx));
        end

        // Asynchronous reset in the middle of effect 3.
        apply(3'd3, 0, 0);
        for (int k = 0; k < 4; k++) apply(3'd0, 1, 0);
        chk_all("pre_rst", 63775, 1, 0, 3, 4);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(3'd5, 1, 0);
        chk_all("after_rst_trig5", 1, 0, 0, 0, 0);
        apply(3'd0, 1, 0);
        chk_all("after_rst_step", 1, 0, 0, 0, 0);
        apply(3'd1, 0, 0);
        chk_all("after_rst_trig1", 50607, 1, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
